mem_lsu: RTL and testbench

//  MEM-stage load/store unit between ex_mem and mem_wb. Issues one data-bus access per load/store,

---
 rtl/mem_lsu_if.sv | 15 +
 rtl/mem_lsu.sv | 164 ++++++++++++++++
 tb/tb_mem_lsu.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the MEM-stage load/store unit and data memory.
// The master side issues requests; the slave side grants them and returns read data.
interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit. Issues one bus access per load/store, stalls the
// pipeline until it completes (or times out), aligns and extends load data and
// hands the writeback bundle to mem_wb. Non-memory instructions pass straight through.
module mem_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] instaddr_i,
  input  logic        regs_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_wr_addr_i,
  input  logic [31:0] csr_wr_data_i,
  input  logic        ls_valid_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  mem_lsu_if.master   dmem,
  output logic        hold_req_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [31:0] inst_o,
  output logic [31:0] instaddr_o,
  output logic        regs_wen_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        csr_wen_o,
  output logic [11:0] csr_wr_addr_o,
  output logic [31:0] csr_wr_data_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             aligned;
  logic             start;
  logic             tmo;
  logic             complete;
  logic             err;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      shifted;
  logic [31:0]      load_data;

  // Access decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    wdata   = ls_wdata_i;
    unique case (ls_size_i)
      2'b00: begin
        aligned = 1'b1;
        be      = 4'b0001 << ls_addr_i[1:0];
        wdata   = {4{ls_wdata_i[7:0]}};
      end
      2'b01: begin
        aligned = ~ls_addr_i[0];
        be      = 4'b0011 << ls_addr_i[1:0];
        wdata   = {2{ls_wdata_i[15:0]}};
      end
      default: begin
        aligned = (ls_addr_i[1:0] == 2'b00);
        be      = 4'b1111;
        wdata   = ls_wdata_i;
      end
    endcase
  end

  assign start = (state_q == IDLE) && ls_valid_i && aligned;
  assign tmo   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus completion/timeout flags; a completion beats a timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dmem.gnt) begin
            if (ls_we_i) complete = 1'b1;
            else         state_d  = WAIT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem.gnt && ls_we_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (dmem.gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem.rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (tmo) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timeout counter restarts on every entry into REQ or WAIT and counts cycles spent there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             cnt_q <= '0;
    else if ((state_d != IDLE) && (state_d != state_q)) cnt_q <= '0;
    else if (state_q != IDLE)                            cnt_q <= cnt_q + 1'b1;
  end

  // Load alignment: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    shifted   = dmem.rdata >> {ls_addr_i[1:0], 3'b000};
    load_data = shifted;
    unique case (ls_size_i)
      2'b00:   load_data = ls_unsigned_i ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = ls_unsigned_i ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign dmem.req   = ~rst & (start | (state_q == REQ));
  assign dmem.we    = ls_we_i;
  assign dmem.addr  = {ls_addr_i[31:2], 2'b00};
  assign dmem.be    = be;
  assign dmem.wdata = wdata;

  assign hold_req_o = ~rst & (start | (state_q != IDLE)) & ~complete & ~err;
  assign misalign_o = ~rst & (state_q == IDLE) & ls_valid_i & ~aligned;
  assign bus_err_o  = ~rst & err;

  assign inst_o        = inst_i;
  assign instaddr_o    = instaddr_i;
  assign rd_addr_o     = rd_addr_i;
  assign rd_data_o     = ((state_q == WAIT) && dmem.rvalid) ? load_data : rd_data_i;
  assign regs_wen_o    = ~rst & regs_wen_i & ~hold_req_o & ~misalign_o & ~err;
  assign csr_wen_o     = ~rst & csr_wen_i & ~hold_req_o;
  assign csr_wr_addr_o = csr_wr_addr_i;
  assign csr_wr_data_o = csr_wr_data_i;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: directed corner cases plus randomized loads/stores,
// each compared against a byte-level behavioural model of the access.
module tb_mem_lsu;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, instaddr_i, rd_data_i, csr_wr_data_i, ls_addr_i, ls_wdata_i;
  logic        regs_wen_i, csr_wen_i, ls_valid_i, ls_we_i, ls_unsigned_i;
  logic [4:0]  rd_addr_i;
  logic [11:0] csr_wr_addr_i;
  logic [1:0]  ls_size_i;
  logic        hold_req_o, misalign_o, bus_err_o, regs_wen_o, csr_wen_o;
  logic [31:0] inst_o, instaddr_o, rd_data_o, csr_wr_data_o;
  logic [4:0]  rd_addr_o;
  logic [11:0] csr_wr_addr_o;

  int checks   = 0;
  int failures = 0;

  mem_lsu_if dmem ();

  mem_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .inst_i(inst_i), .instaddr_i(instaddr_i), .regs_wen_i(regs_wen_i),
    .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .csr_wen_i(csr_wen_i), .csr_wr_addr_i(csr_wr_addr_i), .csr_wr_data_i(csr_wr_data_i),
    .ls_valid_i(ls_valid_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_unsigned_i(ls_unsigned_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .dmem(dmem.master),
    .hold_req_o(hold_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .inst_o(inst_o), .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .csr_wen_o(csr_wen_o), .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_aligned(input logic [1:0] size, input logic [31:0] a);
    return (a % size_bytes(size)) == 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    logic [3:0] r;
    int off;
    int n;
    off = int'(a % 4);
    n   = size_bytes(size);
    r   = '0;
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
    return r;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = size_bytes(size);
    r = '0;
    for (int i = 0; i < 4; i++) r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] size, input logic uns);
    int b[4];
    int off;
    int v;
    off = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = int'((w >> (8 * i)) & 32'hFF);
    if (size == 2'b00) begin
      v = b[off];
      if (!uns && v >= 128) v = v - 256;
    end else if (size == 2'b01) begin
      v = b[off] + 256 * b[off + 1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      return w;
    end
    return 32'(v);
  endfunction

  // Runs one instruction from entry in ex_mem until it leaves; starts and ends at posedge+1.
  task automatic applyStimulus(input logic valid, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input logic [31:0] rdin,
                               input logic rwen, input int gdel, input int rdel,
                               input bit no_gnt, input bit no_rvalid);
    int last;
    bit tmo;
    bit active;
    bit mis;
    logic [31:0] exp_rd;
    inst_i = $urandom; instaddr_i = $urandom; rd_addr_i = 5'($urandom);
    csr_wen_i = 1'($urandom); csr_wr_addr_i = 12'($urandom); csr_wr_data_i = $urandom;
    regs_wen_i = rwen; rd_data_i = rdin;
    ls_valid_i = valid; ls_we_i = we; ls_size_i = size; ls_unsigned_i = uns;
    ls_addr_i = addr; ls_wdata_i = wd;
    mis    = valid && !model_aligned(size, addr);
    active = valid && !mis;
    tmo    = 1'b0;
    if (!active)        last = 0;
    else if (no_gnt)    begin last = TIMEOUT; tmo = 1'b1; end
    else if (we)        last = gdel;
    else if (no_rvalid) begin last = gdel + TIMEOUT; tmo = 1'b1; end
    else                last = gdel + rdel;
    exp_rd = (active && !we && !tmo) ? model_load(rdata, addr, size, uns) : rdin;
    for (int k = 0; k <= last; k++) begin
      dmem.gnt    = active && !no_gnt && (k == gdel);
      dmem.rvalid = active && !we && !no_gnt && !no_rvalid && (k == gdel + rdel);
      dmem.rdata  = dmem.rvalid ? rdata : $urandom;
      #4;
      checkOutput("req", 32'(dmem.req), 32'(active && (no_gnt || k <= gdel)));
      checkOutput("hold", 32'(hold_req_o), 32'(active && k < last));
      checkOutput("bus_err", 32'(bus_err_o), 32'(tmo && k == last));
      checkOutput("misalign", 32'(misalign_o), 32'(mis));
      checkOutput("regs_wen", 32'(regs_wen_o), 32'((k == last && !tmo && !mis) ? rwen : 1'b0));
      checkOutput("csr_wen", 32'(csr_wen_o), 32'((k == last) ? csr_wen_i : 1'b0));
      if (active && k == 0) begin
        checkOutput("we", 32'(dmem.we), 32'(we));
        checkOutput("addr", dmem.addr, addr & 32'hFFFF_FFFC);
        if (we) begin
          checkOutput("be", 32'(dmem.be), 32'(model_be(size, addr)));
          checkOutput("wdata", dmem.wdata, model_wdata(size, wd));
        end
      end
      if (k == last) begin
        checkOutput("rd_data", rd_data_o, exp_rd);
        checkOutput("inst", inst_o, inst_i);
        checkOutput("rd_addr", 32'(rd_addr_o), 32'(rd_addr_i));
        checkOutput("csr_data", csr_wr_data_o, csr_wr_data_i);
      end
      @(posedge clk);
      #1;
    end
    ls_valid_i  = 1'b0;
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_i = '0; instaddr_i = '0; regs_wen_i = 1'b1; rd_addr_i = '0; rd_data_i = '0;
    csr_wen_i = 1'b1; csr_wr_addr_i = '0; csr_wr_data_i = '0;
    ls_valid_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_unsigned_i = 1'b0;
    ls_addr_i = 32'h100; ls_wdata_i = '0;
    dmem.gnt = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    #3;
    checkOutput("rst_req", 32'(dmem.req), 32'd0);
    checkOutput("rst_hold", 32'(hold_req_o), 32'd0);
    checkOutput("rst_regs_wen", 32'(regs_wen_o), 32'd0);
    checkOutput("rst_csr_wen", 32'(csr_wen_o), 32'd0);
    checkOutput("rst_err", 32'(bus_err_o), 32'd0);
    ls_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // pass-through, LB/LBU, SH with late grant, misaligned LW
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234, 1'b1, 0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 32'h5, 1'b1, 0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 32'h5, 1'b1, 0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h102, 32'hABCD, 32'h0, 32'h7, 1'b0, 3, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 32'h9, 1'b1, 0, 1, 1'b0, 1'b0);

    // timeouts in WAIT and in REQ, each followed by a normal instruction
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 32'h11, 1'b1, 0, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 32'h22, 1'b1, 0, 1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h204, 32'h55, 32'h0, 32'h33, 1'b0, 0, 1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h206, 32'h0, 32'h8001_0000, 32'h44, 1'b1, 1, 2, 1'b0, 1'b0);

    // reset while a load waits for rvalid
    regs_wen_i = 1'b1; ls_valid_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_addr_i = 32'h300;
    dmem.gnt = 1'b1;
    @(posedge clk);
    #1;
    dmem.gnt = 1'b0;
    #2;
    checkOutput("wait_hold", 32'(hold_req_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_req", 32'(dmem.req), 32'd0);
    checkOutput("midrst_hold", 32'(hold_req_o), 32'd0);
    checkOutput("midrst_regs_wen", 32'(regs_wen_o), 32'd0);
    ls_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'hCAFE_BABE, 32'h0, 1'b1, 1, 1, 1'b0, 1'b0);

    // randomized mix; address low bits random so misaligned cases arise naturally
    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 0, kind == 2, 2'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom, $urandom, 1'($urandom), $urandom_range(0, 3),
                    $urandom_range(1, 3), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so a stuck run still ends with a summary
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
